// File: rtl/imem_responder.sv
// imem_responder: multicycle instruction-memory responder with valid/ready fetch handshake.
//   clk, rst                 : clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready      : fetch request handshake; req_addr is the byte address
//   flush                    : branch redirect, kills in-flight or held response
//   resp_valid/resp_ready    : response handshake; resp_addr/resp_instr/resp_err held until consumed
//   busy                     : high while a request is counting down its latency
//   prog_we/prog_addr/prog_wdata : program-load write port (word addressed by prog_addr[31:2])
module imem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_addr,
    output logic [31:0] resp_instr,
    output logic        resp_err,
    output logic        busy,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0] addr_q, addr_nx;
    logic [31:0] mem [DEPTH_WORDS];
    logic accept, load_resp, rd_err;
    logic [31:0] rd_addr;
    logic resp_valid_nx, resp_err_nx;
    logic [31:0] resp_addr_nx, resp_instr_nx;
    logic unused_ok;

    assign req_ready = (state == IDLE) || (state == WAIT && flush) ||
                       (state == RESP && (resp_ready || flush));
    assign accept = req_valid && req_ready;
    assign busy = state == WAIT;
    // With LATENCY=1 the response is built from the request being accepted this edge.
    assign rd_addr = accept ? req_addr : addr_q;
    assign rd_err = (rd_addr[1:0] != 2'b00) || (rd_addr[31:2] >= DEPTH_W);
    assign unused_ok = ^prog_addr[1:0];

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        addr_nx = addr_q;
        load_resp = 1'b0;
        resp_valid_nx = resp_valid;
        resp_addr_nx = resp_addr;
        resp_instr_nx = resp_instr;
        resp_err_nx = resp_err;
        case (state)
            WAIT: begin
                if (flush) begin
                    state_nx = IDLE;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state_nx = RESP;
                        load_resp = 1'b1;
                    end
                end
            end
            RESP: begin
                if (flush || resp_ready) begin
                    state_nx = IDLE;
                    resp_valid_nx = 1'b0;
                end
            end
            default: ;
        endcase
        // A new accept overrides whatever the current state decided (flush redirect, back-to-back).
        if (accept) begin
            addr_nx = req_addr;
            if (LATENCY == 1) begin
                state_nx = RESP;
                load_resp = 1'b1;
            end else begin
                state_nx = WAIT;
                cnt_nx = CNT_LOAD;
            end
        end
        // The array is read combinationally here and registered at the edge, so a
        // program write to the same word at that edge is not seen (read-before-write).
        if (load_resp) begin
            resp_valid_nx = 1'b1;
            resp_addr_nx = rd_addr;
            resp_err_nx = rd_err;
            resp_instr_nx = rd_err ? 32'd0 : mem[rd_addr[AW+1:2]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            resp_valid <= 1'b0;
            resp_addr <= '0;
            resp_instr <= '0;
            resp_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            addr_q <= addr_nx;
            resp_valid <= resp_valid_nx;
            resp_addr <= resp_addr_nx;
            resp_instr <= resp_instr_nx;
            resp_err <= resp_err_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_we && prog_addr[31:2] < DEPTH_W)
            mem[prog_addr[AW+1:2]] <= prog_wdata;
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed and randomized checks of imem_responder against a word-array model.
module tb_imem_responder;
    localparam int L = 3;
    localparam int D = 1024;
    localparam int D1 = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic req_valid = 0, flush = 0, resp_ready = 0, prog_we = 0;
    logic [31:0] req_addr = 0, prog_addr = 0, prog_wdata = 0;
    logic req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_addr, resp_instr;

    logic req_valid1 = 0, resp_ready1 = 0, flush1 = 0;
    logic [31:0] req_addr1 = 0;
    logic req_ready1, resp_valid1, resp_err1, busy1;
    logic [31:0] resp_addr1, resp_instr1;

    imem_responder #(.DEPTH_WORDS(D), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
        .resp_instr(resp_instr), .resp_err(resp_err), .busy(busy),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    imem_responder #(.DEPTH_WORDS(D1), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
        .flush(flush1), .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_addr(resp_addr1),
        .resp_instr(resp_instr1), .resp_err(resp_err1), .busy(busy1),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
    );

    logic [31:0] mem_m [D];
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk += 1;
        assert (obs === exp) n_pass += 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic exp_err(input logic [31:0] a, input int depth);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(depth));
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a, input int depth);
        return exp_err(a, depth) ? 32'd0 : mem_m[a >> 2];
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return {20'd0, 10'($urandom_range(0, D - 1)), 2'b00};
        if (r < 8) return {20'd0, 10'($urandom_range(0, D - 1)), 2'($urandom_range(1, 3))};
        if (r == 8) return $urandom | 32'h1000;
        return ($urandom_range(0, 1) != 0) ? 32'hFFC : 32'h1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1; prog_addr = a; prog_wdata = d;
        tick();
        prog_we = 0;
        if ((a >> 2) < 32'(D)) mem_m[a >> 2] = d;
    endtask

    task automatic issue(input logic [31:0] a);
        req_valid = 1; req_addr = a;
        #1;
        chk("req_ready_at_accept", req_ready, 1);
        tick();
        req_valid = 0; resp_ready = 0; flush = 0;
    endtask

    // Response must appear LATENCY-1 edges after acceptance and reflect the array as it
    // stood before the response-entry edge (an optional write lands exactly on that edge).
    task automatic wait_resp(input logic [31:0] a, input bit collide, input logic [31:0] wd,
                             output logic [31:0] e_i, output logic e_e);
        e_i = exp_instr(a, D);
        e_e = exp_err(a, D);
        for (int k = 0; k < L - 1; k++) begin
            chk("busy_in_wait", busy, 1);
            chk("valid_low_in_wait", resp_valid, 0);
            if (collide && k == L - 2) begin
                prog_we = 1; prog_addr = {a[31:2], 2'b00}; prog_wdata = wd;
            end
            tick();
            prog_we = 0;
        end
        if (collide && (a >> 2) < 32'(D)) mem_m[a >> 2] = wd;
        chk("resp_valid", resp_valid, 1);
        chk("resp_addr", resp_addr, a);
        chk("resp_instr", resp_instr, e_i);
        chk("resp_err", resp_err, e_e);
        chk("busy_in_resp", busy, 0);
        chk("req_ready_in_resp", req_ready, 0);
    endtask

    task automatic hold(input logic [31:0] a, input logic [31:0] e_i, input logic e_e, input int n);
        int w;
        resp_ready = 0;
        repeat (n) begin
            w = $urandom_range(0, D - 1);
            prog_we = ($urandom_range(0, 1) != 0);
            prog_addr = 32'(w) << 2; prog_wdata = $urandom;
            tick();
            if (prog_we) mem_m[w] = prog_wdata;
            prog_we = 0;
            chk("hold_valid", resp_valid, 1);
            chk("hold_addr", resp_addr, a);
            chk("hold_instr", resp_instr, e_i);
            chk("hold_err", resp_err, e_e);
            chk("hold_req_ready", req_ready, 0);
        end
    endtask

    task automatic release_resp();
        resp_ready = 1;
        #1;
        chk("req_ready_on_consume", req_ready, 1);
        tick();
        resp_ready = 0;
        chk("valid_after_consume", resp_valid, 0);
        chk("busy_after_consume", busy, 0);
    endtask

    task automatic read_full(input logic [31:0] a, input int n);
        logic [31:0] ei;
        logic ee;
        issue(a);
        wait_resp(a, 0, 0, ei, ee);
        hold(a, ei, ee, n);
        release_resp();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, resp_valid, 0);
        chk({tag, "_addr"}, resp_addr, 0);
        chk({tag, "_instr"}, resp_instr, 0);
        chk({tag, "_err"}, resp_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req_ready"}, req_ready, 1);
    endtask

    task automatic reset_pulse();
        #3 rst = 1;
        #1 chk_reset_outputs("async_rst");
        tick();
        #4 rst = 0;
        repeat (L + 2) begin
            tick();
            chk("no_resp_after_rst", resp_valid, 0);
            chk("no_busy_after_rst", busy, 0);
        end
    endtask

    initial begin
        logic [31:0] a, b, ei;
        logic ee;
        int mode, k;
        #2 chk_reset_outputs("reset");
        #10 rst = 0;
        tick();
        prog_write(32'h0, 32'h20010005);
        prog_write(32'h4, 32'h20020007);
        prog_write(32'h8, 32'h00221820);
        prog_write(32'hC, 32'hAC030010);
        for (int i = 4; i < D; i++) prog_write(32'(i) << 2, $urandom);
        prog_write(32'h1000, 32'h12345678);

        issue(32'h4);
        wait_resp(32'h4, 0, 0, ei, ee);
        chk("basic_instr", resp_instr, 32'h20020007);
        hold(32'h4, ei, ee, 4);
        resp_ready = 1;
        issue(32'h8);
        wait_resp(32'h8, 0, 0, ei, ee);
        chk("b2b_instr", resp_instr, 32'h00221820);
        release_resp();

        issue(32'h40);
        flush = 1;
        issue(32'hC);
        wait_resp(32'hC, 0, 0, ei, ee);
        chk("flush_wait_instr", resp_instr, 32'hAC030010);
        release_resp();

        issue(32'h10);
        wait_resp(32'h10, 0, 0, ei, ee);
        flush = 1; resp_ready = 0;
        tick();
        flush = 0;
        chk("flush_resp_valid", resp_valid, 0);
        chk("flush_resp_busy", busy, 0);
        chk("flush_resp_req_ready", req_ready, 1);

        flush = 1;
        tick();
        flush = 0;
        chk("flush_idle_valid", resp_valid, 0);
        chk("flush_idle_busy", busy, 0);
        read_full(32'h14, 1);

        issue(32'h6);
        wait_resp(32'h6, 0, 0, ei, ee);
        chk("misaligned_err", resp_err, 1);
        chk("misaligned_instr", resp_instr, 0);
        release_resp();
        issue(32'h1000);
        wait_resp(32'h1000, 0, 0, ei, ee);
        chk("oor_err", resp_err, 1);
        release_resp();
        issue(32'hFFC);
        wait_resp(32'hFFC, 0, 0, ei, ee);
        chk("last_word_err", resp_err, 0);
        release_resp();

        issue(32'h0);
        wait_resp(32'h0, 1, 32'hDEADBEEF, ei, ee);
        chk("collision_old_word", resp_instr, 32'h20010005);
        release_resp();
        issue(32'h0);
        wait_resp(32'h0, 0, 0, ei, ee);
        chk("collision_new_word", resp_instr, 32'hDEADBEEF);
        release_resp();

        issue(32'h8);
        reset_pulse();
        issue(32'hC);
        wait_resp(32'hC, 0, 0, ei, ee);
        reset_pulse();
        read_full(32'h8, 0);

        repeat (60) begin
            a = rand_addr();
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                read_full(a, $urandom_range(0, 3));
            end else if (mode == 1) begin
                issue(a);
                k = $urandom_range(0, L - 2);
                repeat (k) begin
                    chk("busy_before_flush", busy, 1);
                    tick();
                end
                b = rand_addr();
                flush = 1;
                issue(b);
                wait_resp(b, 0, 0, ei, ee);
                hold(b, ei, ee, $urandom_range(0, 2));
                release_resp();
            end else if (mode == 2) begin
                issue(a);
                wait_resp(a, 1, $urandom, ei, ee);
                hold(a, ei, ee, $urandom_range(0, 2));
                release_resp();
            end else begin
                issue(a);
                wait_resp(a, 0, 0, ei, ee);
                b = rand_addr();
                resp_ready = 1;
                issue(b);
                wait_resp(b, 0, 0, ei, ee);
                release_resp();
            end
        end

        resp_ready1 = 1;
        for (int i = 0; i < 10; i++) begin
            a = 32'($urandom_range(0, 4 * D1 + 15));
            req_valid1 = 1; req_addr1 = a;
            #1;
            chk("l1_req_ready", req_ready1, 1);
            tick();
            chk("l1_valid", resp_valid1, 1);
            chk("l1_addr", resp_addr1, a);
            chk("l1_instr", resp_instr1, exp_instr(a, D1));
            chk("l1_err", resp_err1, exp_err(a, D1));
            chk("l1_busy", busy1, 0);
        end
        req_valid1 = 0;
        tick();
        chk("l1_valid_drop", resp_valid1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
# imem_responder

Multicycle instruction-memory responder serving the fetch stage's instruction requests over a valid/ready handshake with a fixed, parameterised access latency. It replaces the zero-latency instruction ROM behind the fetch stage. It holds each response until the fetch stage consumes it, and discards in-flight work when a branch redirect flushes the front end. A program-load write port fills the array before and during simulation.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; byte range is 0 to 4*DEPTH_WORDS-1.
- `LATENCY`, 3: cycles from request acceptance to response visibility. Must be ≥1.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: fetch request present.
- `req_addr` in 32: byte address of the requested instruction.
- `req_ready` out 1: request accepted at this edge if `req_valid` is high.
- `flush` in 1: branch redirect; kill any in-flight or held response.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: fetch stage consumes the response at this edge.
- `resp_addr` out 32: `req_addr` of the request being answered.
- `resp_instr` out 32: instruction word; 0 when `resp_err` is high.
- `resp_err` out 1: address misaligned (`addr[1:0]` ≠ 0) or out of range (`addr[31:2]` ≥ DEPTH_WORDS).
- `busy` out 1: high in WAIT; the fetch stage uses it as its memory freeze.
- `prog_we` in 1: program-load write enable.
- `prog_addr` in 32: program-load byte address; bits [1:0] ignored; out-of-range writes are dropped.
- `prog_wdata` in 32: program-load data.

## Operation
- States:
  - IDLE: no request outstanding.
  - WAIT: latency countdown.
  - RESP: response held.
- `req_ready` is combinational and high in any of these cases:
  - state IDLE;
  - state WAIT with `flush` high;
  - state RESP with `resp_ready` or `flush` high.
- Accept means `req_valid` and `req_ready` are both high at an edge. On accept:
  - latch `req_addr` into an internal address register;
  - if LATENCY=1, go to RESP and load the outputs, as described under entering RESP;
  - otherwise go to WAIT with the counter loaded to LATENCY-1.
- WAIT:
  - each edge decrements the counter;
  - at the edge where the counter equals 1, go to RESP.
- Entering RESP registers the outputs:
  - `resp_valid` = 1;
  - `resp_addr` = latched address;
  - `resp_err` = error check on the latched address;
  - `resp_instr` = array word when there is no error, otherwise 0.
- RESP:
  - outputs are held stable until an edge with `resp_ready` high;
  - that edge goes to IDLE, or takes a new accept if `req_valid` is high, giving back-to-back operation.
- `flush` has priority over the in-flight request:
  - WAIT: abort, with no response ever produced;
  - RESP: drop `resp_valid` at the next edge, whatever `resp_ready` is;
  - in both cases, a `req_valid` in the same cycle as `flush` is accepted as the redirected fetch;
  - in IDLE, `flush` has no effect.
- `prog_we` writes `mem[prog_addr[31:2]]` at the edge.
  - Array reads are read-before-write.
  - If a write and the RESP-entry read hit the same word at the same edge, the response returns the old word.
- Array contents are not reset.

## Timing
- Reset values:
  - state = IDLE, counter = 0;
  - `resp_valid` = 0, `resp_addr` = 0, `resp_instr` = 0, `resp_err` = 0, `busy` = 0;
  - `req_ready` = 1.
- Latency:
  - request accepted at edge E0 gives `resp_valid` high right after edge E0+LATENCY-1;
  - LATENCY=1: response visible in the cycle right after acceptance.
- Throughput: one request every LATENCY cycles with `resp_ready` held high; no request overlap.
- `busy` is registered state decode: high exactly in WAIT cycles.
- Reset asserted mid-WAIT or mid-RESP:
  - all outputs take their reset values immediately, without waiting for a clock edge;
  - the in-flight request is lost, and no response appears after reset releases.
- `req_valid` is ignored when `req_ready` is low; the requester must hold `req_addr` until accepted.

## Test plan
- **Basic read:** load words 0–3 with 0x20010005, 0x20020007, 0x00221820, 0xAC030010; accept `req_addr`=0x4 at edge 1 (LATENCY=3). Expect `resp_valid` high after edge 3 with `resp_addr`=0x4 and `resp_instr`=0x20020007. Expect `busy` high after edges 1–2.
- **Backpressure:** hold `resp_ready`=0 for 4 cycles. Expect response fields stable and `req_ready`=0. Then drive `resp_ready`=1 with `req_valid` and addr 0x8. Expect acceptance at the same edge and `resp_instr`=0x00221820 three cycles later.
- **Flush:**
  - Accept 0x40, then assert `flush` one cycle later together with a request for 0xC. Expect no response for 0x40, then the 0xC response carrying 0xAC030010.
  - Flush while in RESP. Expect `resp_valid`=0 after that edge.
- **Errors:**
  - `req_addr`=0x6: `resp_err`=1, `resp_instr`=0, after the normal 3-cycle latency.
  - `req_addr`=0x1000: `resp_err`=1.
  - `req_addr`=0xFFC: `resp_err`=0.
- **Write collision:** accept 0x0; at the RESP-entry edge write 0xDEADBEEF to word 0. Expect the response to be 0x20010005 and a following fetch of 0x0 to return 0xDEADBEEF.
- **Reset mid-operation:** assert `rst` during WAIT, between edges. Expect `busy`, `resp_valid` and the response fields to clear before the next edge, and no response after release. With LATENCY=1 (separate build), expect a response one cycle after each accept.
